bit_scan_encode: RTL



---
 rtl/bit_scan_pkg.sv | 30 +++
 rtl/bit_scan_encode_if.sv | 41 ++++
 rtl/bit_scan_pick.sv | 33 +++
 rtl/bit_scan_encode.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit_scan_encode block.
// Provides the FSM state encoding, a constant clog2 and a popcount helper.
package bit_scan_pkg;

    localparam int unsigned MAX_WIDTH = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bit_scan_encode_if.sv
// Request/index handshake bundle for bit_scan_encode.
// out_cnt is present only when BIT_SCAN_CNT_EN is defined.
interface bit_scan_encode_if
    import bit_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned IDX_W = clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_code;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] out_onehot;
    logic             out_last;
    logic             out_none;
`ifdef BIT_SCAN_CNT_EN
    logic [IDX_W:0]   out_cnt;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_idx, out_onehot, out_last, out_none, out_cnt
    );
    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_idx, out_onehot, out_last, out_none, out_cnt
    );
`else
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_idx, out_onehot, out_last, out_none
    );
    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_idx, out_onehot, out_last, out_none
    );
`endif

endinterface

// File: rtl/bit_scan_pick.sv
// Combinational find-first-set: returns the highest-priority set bit of vec.
// MSB_FIRST=0 gives bit 0 top priority, MSB_FIRST=1 gives bit WIDTH-1 top priority.
module bit_scan_pick
    import bit_scan_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic [WIDTH-1:0]           vec,
    output logic [clog2(WIDTH)-1:0]    idx,
    output logic [WIDTH-1:0]           onehot,
    output logic                       found
);
    localparam int unsigned IDX_W = clog2(WIDTH);

    int unsigned pos;

    always_comb begin
        idx    = '0;
        onehot = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pos = (MSB_FIRST != 0) ? (WIDTH - 1 - i) : i;
            if (!found && vec[pos]) begin
                found       = 1'b1;
                idx         = IDX_W'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_scan_encode.sv
// Emits the index of every set bit of an accepted request word, one beat per index.
// Optional out_cnt (popcount of the accepted word) is enabled by BIT_SCAN_CNT_EN.
module bit_scan_encode
    import bit_scan_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_scan_encode_if.slave       bus,
    output logic                   busy
);
    localparam int unsigned IDX_W = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] residual_q, residual_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             none_q, none_d;

    logic [IDX_W-1:0] in_idx, res_idx;
    logic [WIDTH-1:0] in_oh, res_oh;
    logic             in_found, res_found;
    logic [WIDTH-1:0] load_residual, next_residual;
    logic             out_valid, accept, xfer;

    bit_scan_pick #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_pick_in (
        .vec    (bus.in_code),
        .idx    (in_idx),
        .onehot (in_oh),
        .found  (in_found)
    );

    bit_scan_pick #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_pick_res (
        .vec    (residual_q),
        .idx    (res_idx),
        .onehot (res_oh),
        .found  (res_found)
    );

    assign out_valid     = (state_q == ST_EMIT);
    assign bus.in_ready  = ~rst & (~out_valid | (bus.out_ready & last_q));
    assign accept        = bus.in_valid & bus.in_ready;
    assign xfer          = out_valid & bus.out_ready;
    assign load_residual = bus.in_code & ~in_oh;
    assign next_residual = residual_q & ~res_oh;

`ifdef BIT_SCAN_CNT_EN
    logic [IDX_W:0]         cnt_q, cnt_d;
    logic [MAX_WIDTH-1:0]   padded_code;

    always_comb begin
        padded_code              = '0;
        padded_code[WIDTH-1:0]   = bus.in_code;
    end
`endif

    // A final-beat transfer may coincide with a new accept; the load branch
    // then takes priority over returning to IDLE so words stream back-to-back.
    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        onehot_d   = onehot_q;
        idx_d      = idx_q;
        last_d     = last_q;
        none_d     = none_q;
`ifdef BIT_SCAN_CNT_EN
        cnt_d      = cnt_q;
`endif
        if (accept) begin
            state_d    = ST_EMIT;
            idx_d      = in_idx;
            onehot_d   = in_oh;
            residual_d = load_residual;
            last_d     = (load_residual == '0);
            none_d     = ~in_found;
`ifdef BIT_SCAN_CNT_EN
            cnt_d      = (IDX_W+1)'(popcount(padded_code));
`endif
        end else if (xfer) begin
            if (!last_q && res_found) begin
                idx_d      = res_idx;
                onehot_d   = res_oh;
                residual_d = next_residual;
                last_d     = (next_residual == '0);
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            residual_q <= '0;
            onehot_q   <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            none_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            onehot_q   <= onehot_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            none_q     <= none_d;
        end
    end

`ifdef BIT_SCAN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.out_cnt = cnt_q;
`endif

    assign bus.out_valid  = out_valid;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;
    assign bus.out_last   = last_q;
    assign bus.out_none   = none_q;
    assign busy           = out_valid;

endmodule
